// File: rtl/addsub_pkg.sv
// Shared types and constants for the sequential add/sub unit (addsub_seq).
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bit i of the W-bit saturation constant: 0111..1 when neg=0, 1000..0 when neg=1.
  function automatic logic sat_bit(input int w, input int i, input logic neg);
    return (i == w - 1) ? neg : ~neg;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit slice of the add/sub datapath; b is inverted for subtract.
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             m,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_top
);

  logic [CHUNK-1:0] w_b;
  logic [CHUNK:0]   w_full;

  assign w_b    = (m == MODE_ADD) ? b : ~b;
  assign w_full = {1'b0, a} + {1'b0, w_b} + {{CHUNK{1'b0}}, cin};
  assign sum    = w_full[CHUNK-1:0];
  assign cout   = w_full[CHUNK];

  // The top sum bit is a ^ b ^ carry_in, so the carry into it falls out by XOR.
  assign c_top  = w_full[CHUNK-1] ^ a[CHUNK-1] ^ w_b[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle W-bit adder/subtractor, CHUNK bits per clock, valid/ready on both sides.
// Build option: define ADDSUB_SAT_EN to clamp the result on signed overflow.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int W     = 8,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int NCH = W / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  state_t         r_state;
  logic [IW-1:0]  r_idx;
  logic           r_carry;
  logic           r_m;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_res;
  logic           r_cout;
  logic           r_ovf;
  logic           r_zero;

  logic [CHUNK-1:0] w_a_ch;
  logic [CHUNK-1:0] w_b_ch;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_c_top;
  logic             w_last;
  logic             w_ovf;
  logic [W-1:0]     w_res_next;
  logic [W-1:0]     w_res_final;

  assign w_a_ch = r_a[int'(r_idx)*CHUNK +: CHUNK];
  assign w_b_ch = r_b[int'(r_idx)*CHUNK +: CHUNK];
  assign w_last = (r_idx == IW'(NCH - 1));
  assign w_ovf  = w_c_top ^ w_cout;

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (w_a_ch),
    .b     (w_b_ch),
    .m     (r_m),
    .cin   (r_carry),
    .sum   (w_sum),
    .cout  (w_cout),
    .c_top (w_c_top)
  );

  always_comb begin
    // NOTE: each always_comb target gets a default before any conditional write, so no latch is inferred.
    w_res_next = r_res;
    w_res_next[int'(r_idx)*CHUNK +: CHUNK] = w_sum;
    w_res_final = w_res_next;
`ifdef ADDSUB_SAT_EN
    if (w_last && w_ovf) begin
      for (int i = 0; i < W; i++) begin
        w_res_final[i] = sat_bit(W, i, r_a[W-1]);
      end
    end
`endif
  end

  // Operand registers are only read in RUN after being loaded, so they carry no reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) so every register samples pre-edge values.
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_m     <= m;
            r_idx   <= '0;
            r_carry <= (m == MODE_SUB);
            r_res   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res   <= w_res_final;
          r_carry <= w_cout;
          if (w_last) begin
            r_cout  <= w_cout;
            r_ovf   <= w_ovf;
            r_zero  <= (w_res_final == '0);
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign s         = r_res;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq: three instances (CHUNK = 2, 1, 8) at W = 8.
module tb_addsub_seq;
  import addsub_pkg::*;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vm;
    logic [7:0] s_wrap;
    logic       z_wrap;
    logic [7:0] s_sat;
    logic       z_sat;
    logic       cout;
    logic       ovf;
  } vec_t;

  typedef struct packed {
    logic [1:0] d;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       m;
  logic [2:0] in_valid;
  logic [2:0] in_ready;
  logic [2:0] out_valid;
  logic [2:0] out_ready;
  logic [2:0] cout;
  logic [2:0] ovf;
  logic [2:0] zero;
  logic [7:0] s [3];

  int   n_checks;
  int   n_errors;
  exp_t sb[$];
  vec_t vecs[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 2 : ((g == 1) ? 1 : 8);
    addsub_seq #(
      .W     (8),
      .CHUNK (CH)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a),
      .b         (b),
      .m         (m),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .s         (s[g]),
      .cout      (cout[g]),
      .ovf       (ovf[g]),
      .zero      (zero[g])
    );
  end

  function automatic int nch(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 8 : 1);
  endfunction

  function automatic vec_t mk(input logic [7:0] va, input logic [7:0] vb, input logic vm,
                              input logic [7:0] sw, input logic zw, input logic [7:0] ss,
                              input logic zs, input logic c, input logic o);
    vec_t v;
    v.va = va; v.vb = vb; v.vm = vm;
    v.s_wrap = sw; v.z_wrap = zw; v.s_sat = ss; v.z_sat = zs;
    v.cout = c; v.ovf = o;
    return v;
  endfunction

  function automatic exp_t expect_of(input int d, input vec_t v);
    exp_t e;
    e.d    = 2'(d);
    e.s    = SAT ? v.s_sat : v.s_wrap;
    e.zero = SAT ? v.z_sat : v.z_wrap;
    e.cout = v.cout;
    e.ovf  = v.ovf;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (out_valid[d] && out_ready[d]) begin
          if (sb.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid[d]), 32'd0);
          end else begin
            e = sb.pop_front();
            check("sb_dut", d, 32'(e.d));
            check("sb_s", 32'(s[d]), 32'(e.s));
            check("sb_cout", 32'(cout[d]), 32'(e.cout));
            check("sb_ovf", 32'(ovf[d]), 32'(e.ovf));
            check("sb_zero", 32'(zero[d]), 32'(e.zero));
          end
        end
      end
    end
  endtask

  // Present one operation, wait for the accept edge, then scramble the operand inputs.
  task automatic issue(input int d, input vec_t v, input bit push);
    int n;
    n = 0;
    while (!in_ready[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 32'(in_ready[d]), 32'd1);
    a = v.va;
    b = v.vb;
    m = v.vm;
    in_valid[d] = 1'b1;
    if (push) sb.push_back(expect_of(d, v));
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    a = ~v.va;
    b = ~v.vb;
    m = ~v.vm;
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (!out_valid[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, nch(d));
  endtask

  task automatic run_op(input int d, input vec_t v);
    issue(d, v, 1'b1);
    wait_done(d);
    @(posedge clk); #1;
    check("idle_after_done", 32'(in_ready[d]), 32'd1);
  endtask

  task automatic check_cleared(input int d);
    check("rst_in_ready", 32'(in_ready[d]), 32'd1);
    check("rst_out_valid", 32'(out_valid[d]), 32'd0);
    check("rst_s", 32'(s[d]), 32'd0);
    check("rst_cout", 32'(cout[d]), 32'd0);
    check("rst_ovf", 32'(ovf[d]), 32'd0);
    check("rst_zero", 32'(zero[d]), 32'd0);
  endtask

  task automatic reset_mid_run(input int d);
    int k;
    k = (nch(d) > 2) ? 2 : nch(d) - 1;
    issue(d, vecs[1], 1'b0);
    repeat (k) begin
      @(posedge clk); #1;
    end
    check("mid_run_busy", 32'(in_ready[d]), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_cleared(d);
    run_op(d, vecs[0]);
  endtask

  task automatic backpressure();
    exp_t e;
    e = expect_of(0, vecs[3]);
    out_ready[0] = 1'b0;
    issue(0, vecs[3], 1'b1);
    wait_done(0);
    for (int k = 0; k < 5; k++) begin
      check("bp_s", 32'(s[0]), 32'(e.s));
      check("bp_cout", 32'(cout[0]), 32'(e.cout));
      check("bp_ovf", 32'(ovf[0]), 32'(e.ovf));
      check("bp_zero", 32'(zero[0]), 32'(e.zero));
      check("bp_in_ready", 32'(in_ready[0]), 32'd0);
      check("bp_out_valid", 32'(out_valid[0]), 32'd1);
      in_valid[0] = (k % 2 == 0);
      a = 8'h11;
      b = 8'h22;
      m = MODE_ADD;
      @(posedge clk); #1;
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready[0]), 32'd1);
    check("bp_release_out_valid", 32'(out_valid[0]), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 3'b111;
    a         = '0;
    b         = '0;
    m         = MODE_ADD;

    //           A      B      m         s_wrap z  s_sat  z  cout ovf
    vecs[0] = mk(8'hFF, 8'h01, MODE_ADD, 8'h00, 1, 8'h00, 1, 1, 0);
    vecs[1] = mk(8'h7F, 8'h01, MODE_ADD, 8'h80, 0, 8'h7F, 0, 0, 1);
    vecs[2] = mk(8'h80, 8'h01, MODE_SUB, 8'h7F, 0, 8'h80, 0, 1, 1);
    vecs[3] = mk(8'h6C, 8'hCA, MODE_SUB, 8'hA2, 0, 8'h7F, 0, 0, 1);
    vecs[4] = mk(8'h55, 8'hAA, MODE_ADD, 8'hFF, 0, 8'hFF, 0, 0, 0);
    vecs[5] = mk(8'h80, 8'h80, MODE_ADD, 8'h00, 1, 8'h80, 0, 1, 1);
    vecs[6] = mk(8'h00, 8'h00, MODE_SUB, 8'h00, 1, 8'h00, 1, 1, 0);
    vecs[7] = mk(8'h05, 8'h07, MODE_SUB, 8'hFE, 0, 8'hFE, 0, 0, 0);

    fork
      monitor_loop();
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) check_cleared(d);

    for (int i = 0; i < 3; i++) run_op(0, vecs[i]);
    backpressure();
    for (int i = 4; i < 8; i++) run_op(0, vecs[i]);

    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 8; i++) run_op(d, vecs[i]);
    end

    for (int d = 0; d < 3; d++) reset_mid_run(d);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
